// File: rtl/mux2_arbiter_pkg.sv
// Shared types and constants for the two-requester round-robin arbiter.
//   state_t      : arbiter FSM states (IDLE, GRANT0, GRANT1), 2-bit binary
//   LAST_GNT_RST : reset value of the round-robin pointer (1 => req0 wins first tie)
package mux2_arbiter_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'b00,
      GRANT0 = 2'b01,
      GRANT1 = 2'b10
   } state_t;

   localparam logic LAST_GNT_RST = 1'b1;

endpackage

// File: rtl/mux2_dreg.sv
// Registered 2:1 data mux with valid strobe; dout holds while vld_in is low.
//   clk, rst_n : clock, async active-low reset
//   sel        : 0 = din0, 1 = din1
//   vld_in     : current word belongs to a granted, still-requesting source
//   din0, din1 : candidate words
//   dout       : registered selected word
//   dout_vld   : registered valid
module mux2_dreg #(
   parameter int unsigned DW = 8
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          sel,
   input  logic          vld_in,
   input  logic [DW-1:0] din0,
   input  logic [DW-1:0] din1,
   output logic [DW-1:0] dout,
   output logic          dout_vld
);

   // Output word register; only a valid word replaces the held value
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         dout     <= '0;
         dout_vld <= 1'b0;
      end else begin
         dout_vld <= vld_in;
         if (vld_in) begin
            dout <= sel ? din1 : din0;
         end
      end
   end

endmodule

// File: rtl/mux2_arbiter.sv
// Two-requester round-robin arbiter driving a registered 2:1 data mux.
// Optional hold limit: define MUX2_ARBITER_HOLD_LIMIT_EN to force a handover
// (or re-grant) after MAX_HOLD consecutive grant cycles; without it a grant
// lasts until its request drops.
//   sys_clk, sys_rst_n : clock, async active-low reset
//   req0, req1         : level requests
//   din0, din1         : requester data words
//   gnt0, gnt1         : registered grants (mutually exclusive)
//   sel                : registered mux select, holds its value in IDLE
//   dout, dout_vld     : registered selected word and valid, one cycle after gnt
module mux2_arbiter
   import mux2_arbiter_pkg::*;
#(
   parameter int unsigned DW       = 8,
   parameter int unsigned MAX_HOLD = 16
) (
   input  logic          sys_clk,
   input  logic          sys_rst_n,
   input  logic          req0,
   input  logic          req1,
   input  logic [DW-1:0] din0,
   input  logic [DW-1:0] din1,
   output logic          gnt0,
   output logic          gnt1,
   output logic          sel,
   output logic [DW-1:0] dout,
   output logic          dout_vld
);

   state_t state, state_nxt;
   logic   last_gnt;
   logic   grant_new;
   logic   expire;

`ifdef MUX2_ARBITER_HOLD_LIMIT_EN
   localparam int unsigned HW = $clog2(MAX_HOLD);

   logic [HW-1:0] hold_cnt;

   assign expire = (hold_cnt == HW'(MAX_HOLD - 1));

   // Hold counter: restarts on any grant entry, counts while a grant persists
   always_ff @(posedge sys_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         hold_cnt <= '0;
      end else if (grant_new || (state_nxt == IDLE)) begin
         hold_cnt <= '0;
      end else if (state != IDLE) begin
         hold_cnt <= hold_cnt + HW'(1);
      end
   end
`else
   logic unused_max_hold;

   assign expire          = 1'b0;
   assign unused_max_hold = ^32'(MAX_HOLD);
`endif

   // State, grant, select and round-robin pointer registers
   always_ff @(posedge sys_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         state    <= IDLE;
         gnt0     <= 1'b0;
         gnt1     <= 1'b0;
         sel      <= 1'b0;
         last_gnt <= LAST_GNT_RST;
      end else begin
         state <= state_nxt;
         gnt0  <= (state_nxt == GRANT0);
         gnt1  <= (state_nxt == GRANT1);
         if (state_nxt == GRANT0) begin
            sel <= 1'b0;
         end else if (state_nxt == GRANT1) begin
            sel <= 1'b1;
         end
         if (grant_new) begin
            last_gnt <= (state_nxt == GRANT1);
         end
      end
   end

   // Next-state logic; grant_new marks every grant entry including re-grant
   always_comb begin
      state_nxt = state;
      grant_new = 1'b0;
      case (state)
         IDLE: begin
            if (req0 && (!req1 || last_gnt)) begin
               state_nxt = GRANT0;
               grant_new = 1'b1;
            end else if (req1) begin
               state_nxt = GRANT1;
               grant_new = 1'b1;
            end
         end
         GRANT0: begin
            if (!req0 || expire) begin
               grant_new = req1 || req0;
               if (req1) begin
                  state_nxt = GRANT1;
               end else if (!req0) begin
                  state_nxt = IDLE;
               end
            end
         end
         GRANT1: begin
            if (!req1 || expire) begin
               grant_new = req0 || req1;
               if (req0) begin
                  state_nxt = GRANT0;
               end else if (!req1) begin
                  state_nxt = IDLE;
               end
            end
         end
         default: begin
            state_nxt = IDLE;
         end
      endcase
   end

   // A word is valid only while its requester is both granted and requesting
   mux2_dreg #(.DW(DW)) u_dreg (
      .clk      (sys_clk),
      .rst_n    (sys_rst_n),
      .sel      (sel),
      .vld_in   ((gnt0 & req0) | (gnt1 & req1)),
      .din0     (din0),
      .din1     (din1),
      .dout     (dout),
      .dout_vld (dout_vld)
   );

endmodule
